// File: rtl/display_seq_if.sv
// Handshake and status bundle for display_seq. The bench drives the master side,
// and the display sequencer drives the slave side.
interface display_seq_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // in_rdy high at posedge k arms a capture, and data_in is sampled at posedge k+1.
  // in_rdy held high captures data_in on every cycle after the first.
  logic             in_rdy;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_rdy;
  logic             state_cmp;
  logic             busy;
  logic [CW-1:0]    fifo_cnt;
  logic             ovf;
  logic [1:0]       state_dbg;

  modport master (
    output in_rdy, data_in,
    input  data_out, out_rdy, state_cmp, busy, fifo_cnt, ovf, state_dbg
  );

  modport slave (
    input  in_rdy, data_in,
    output data_out, out_rdy, state_cmp, busy, fifo_cnt, ovf, state_dbg
  );
endinterface

// File: rtl/display_seq.sv
// Buffered display stage: a FIFO of captured values, each shown on data_out for HOLD_CYCLES cycles.
// Defining COUNTDOWN_EN makes each shown value count down to 0, one step per HOLD_CYCLES.
module display_seq #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 10
) (
  input  logic         clk,
  input  logic         rst,
  display_seq_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             arm;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf_q;
  logic [WIDTH-1:0] dout_q, dout_nx;
  logic             ordy_q, ordy_nx;
  logic             scmp_q, scmp_nx;
  logic [HW-1:0]    hold_q, hold_nx;
  logic             pop;
  logic             push;
  logic             full;

  assign full = (cnt == CW'(DEPTH));
  assign push = arm && !full;

  // A push is honoured only when the FIFO has space. An armed capture into a full FIFO is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      arm <= bus.in_rdy;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (arm && full) ovf_q <= 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      dout_q <= '0;
      ordy_q <= 1'b0;
      scmp_q <= 1'b0;
      hold_q <= '0;
    end else begin
      state  <= state_nx;
      dout_q <= dout_nx;
      ordy_q <= ordy_nx;
      scmp_q <= scmp_nx;
      hold_q <= hold_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dout_nx  = dout_q;
    ordy_nx  = 1'b0;
    scmp_nx  = 1'b0;
    hold_nx  = hold_q;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        // The pop reads the registered head, so a value must land in the FIFO before it can be shown.
        if (cnt != '0) begin
          pop      = 1'b1;
          dout_nx  = mem[rd_ptr];
          ordy_nx  = 1'b1;
          hold_nx  = HOLD_LOAD;
          state_nx = SHOW;
        end else begin
          dout_nx = '0;
        end
      end
      SHOW: begin
        if (hold_q == '0) begin
`ifdef COUNTDOWN_EN
          if (dout_q != '0) begin
            dout_nx = dout_q - WIDTH'(1);
            hold_nx = HOLD_LOAD;
          end else begin
            dout_nx  = '0;
            scmp_nx  = 1'b1;
            state_nx = DONE;
          end
`else
          dout_nx  = '0;
          scmp_nx  = 1'b1;
          state_nx = DONE;
`endif
        end else begin
          hold_nx = hold_q - HW'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        dout_nx  = '0;
      end
    endcase
  end

  assign bus.data_out  = dout_q;
  assign bus.out_rdy   = ordy_q;
  assign bus.state_cmp = scmp_q;
  assign bus.busy      = (state != IDLE) || (cnt != '0);
  assign bus.fifo_cnt  = cnt;
  assign bus.ovf       = ovf_q;
  assign bus.state_dbg = state;
endmodule

// File: doc/display_seq.md
Name: display_seq

Overview:
Parametrised, buffered successor to the single-value ticket display stage of the vending machine.
- Accepts values over a ready-strobe/data handshake: in_rdy pulse, then data on the next cycle.
- Queues accepted values in a FIFO.
- Presents each value on data_out for a programmable hold time, flagging start (out_rdy) and completion (state_cmp).
- Sits between the fare/change logic and the display driver, so back-to-back transactions are no longer lost while a value is being shown.

Parameters:
WIDTH, 8, data bit width
DEPTH, 4, FIFO entries (>=2, power of 2)
HOLD_CYCLES, 10, clock cycles each displayed value is held (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
in_rdy  input  1  arms capture; data_in is sampled on the following posedge
data_in  input  WIDTH  value to display
data_out  output  WIDTH  displayed value; 0 when idle
out_rdy  output  1  one-cycle pulse when a new value is loaded onto data_out
state_cmp  output  1  one-cycle pulse when the hold of a value completes
busy  output  1  high in SHOW or DONE, or when FIFO not empty
fifo_cnt  output  $clog2(DEPTH+1)  current FIFO occupancy
ovf  output  1  sticky: a capture was dropped because the FIFO was full

Behaviour:
- Reset (rst=0, async): data_out=0, out_rdy=0, state_cmp=0, ovf=0, fifo_cnt=0, busy=0, arm=0, FSM=IDLE, FIFO contents discarded. Applies mid-SHOW as well.
- Capture:
  - posedge k with in_rdy=1 sets arm.
  - posedge k+1 with arm=1 pushes data_in into the FIFO.
  - arm stays set at k+1 only if in_rdy=1 at k+1, so holding in_rdy high pushes every cycle after the first.
- Full FIFO at a push: value dropped, ovf set until reset, fifo_cnt unchanged.
- Push and pop in the same cycle are both honoured; fifo_cnt is unchanged. There is no bypass: an empty FIFO must register the push before it can be popped.
- FSM states: IDLE, SHOW, DONE.
- IDLE:
  - If fifo_cnt>0: pop; data_out<=head; out_rdy<=1; hold_cnt<=HOLD_CYCLES-1; go to SHOW.
  - Otherwise stay in IDLE with data_out=0.
- SHOW:
  - out_rdy<=0.
  - If hold_cnt==0: data_out<=0, state_cmp<=1, go to DONE.
  - Otherwise decrement hold_cnt.
- DONE: state_cmp<=0; go to IDLE. The next pop happens at the following posedge at the earliest.
- Latency: in_rdy sampled at posedge k → data_out valid and out_rdy high after posedge k+2. data_out holds for exactly HOLD_CYCLES cycles. state_cmp is high for the cycle after posedge k+2+HOLD_CYCLES.
- Gap between consecutive displayed values is 2 cycles (DONE + IDLE pop).
- A value of 0 is displayed like any other value; out_rdy and state_cmp pulse normally.
- FIFO pointers wrap modulo DEPTH.
- Only rst clears ovf. in_rdy during SHOW is accepted normally.

Optional Feature:
COUNTDOWN_EN
- Defined: SHOW counts down.
  - data_out starts at the popped value v.
  - Each time hold_cnt expires with data_out>0, data_out decrements by 1 and hold_cnt reloads to HOLD_CYCLES-1.
  - When hold_cnt expires with data_out==0, go to DONE.
  - Total display time is (v+1)*HOLD_CYCLES cycles. out_rdy pulses only on the initial load.
- Undefined: static hold as above; the decrement logic is absent.

Test Plan:
- Reset, in_rdy=1 one cycle, then data_in=5 → out_rdy pulse at k+2; data_out=5 for 10 cycles; state_cmp one pulse; data_out=0; busy falls after DONE.
- Two transactions, 5 then 10 (10 issued during display of 5) → 5 shown 10 cycles, 2-cycle gap, then 10 shown 10 cycles; two out_rdy and two state_cmp pulses; ovf=0.
- in_rdy held high 6 cycles with data_in 1..6 on successive cycles (DEPTH=4) → values 1,2,3,4,5 displayed in order; 6 dropped; ovf=1; fifo_cnt peaks at 4.
- rst asserted mid-SHOW while displaying 7 with 2 entries queued → all outputs 0 immediately; fifo_cnt=0; nothing displayed after release.
- data_in=0 → out_rdy pulse, data_out=0 for 10 cycles, state_cmp pulse.
- COUNTDOWN_EN, HOLD_CYCLES=2, value 3 → data_out 3,3,2,2,1,1,0,0, then state_cmp; total 8 cycles.
